param_accumulator: RTL

Parametrised accumulator: a registered sum of an input stream. Width is configurable, and so are signed or unsigned arithmetic and wrap or saturate overflow handling. Per-cycle controls select add or subtract, and there is a synchronous clear and a load. A sticky overflow flag and an accumulation counter sit alongside the sum. It is the general-purpose successor to the fixed 4-bit up-accumulator in the Counter library, and serves as the building block for averaging and integrate-and-dump datapaths.

---
 rtl/param_accumulator_pkg.sv | 16 +
 rtl/param_accumulator_addsub_sat.sv | 32 +++
 rtl/param_accumulator.sv | 60 ++++++
 3 files changed

// File: rtl/param_accumulator_pkg.sv
// param_accumulator_pkg: mode constants and range-limit helpers shared by counters/accumulators
package param_accumulator_pkg;
    localparam bit WRAP = 1'b0;
    localparam bit SAT  = 1'b1;
    localparam bit UNS  = 1'b0;
    localparam bit SGN  = 1'b1;

    // Limits are returned sign-extended to 64 bits; callers keep the low width bits
    function automatic logic [63:0] max_val(input int width, input bit sgn);
        return sgn ? (64'd1 << (width - 1)) - 64'd1 : (width >= 64 ? '1 : (64'd1 << width) - 64'd1);
    endfunction

    function automatic logic [63:0] min_val(input int width, input bit sgn);
        return sgn ? ~64'd0 << (width - 1) : 64'd0;
    endfunction
endpackage

// File: rtl/param_accumulator_addsub_sat.sv
// param_accumulator_addsub_sat: one-bit-wider add/subtract with overflow detection and optional clamp
module param_accumulator_addsub_sat
    import param_accumulator_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] d,
    input  logic         sub,
    input  logic         sgn,
    input  logic         sat,
    output logic [W-1:0] nq,
    output logic         ovf
);
    localparam logic [63:0] UMAX = max_val(W, UNS);
    localparam logic [63:0] UMIN = min_val(W, UNS);
    localparam logic [63:0] SMAX = max_val(W, SGN);
    localparam logic [63:0] SMIN = min_val(W, SGN);

    logic [W:0]   sum;
    logic         ovf_s;
    logic [W-1:0] lim;

    always_comb begin
        sum = sub ? {1'b0, q} - {1'b0, d} : {1'b0, q} + {1'b0, d};
        // Signed overflow flips the sign of Q when operand signs allow it; its direction follows Q's sign
        ovf_s = (q[W-1] ^ sum[W-1]) & (sub ? q[W-1] ^ d[W-1] : ~(q[W-1] ^ d[W-1]));
        ovf = sgn ? ovf_s : sum[W];
        lim = sgn ? (q[W-1] ? SMIN[W-1:0] : SMAX[W-1:0]) : (sub ? UMIN[W-1:0] : UMAX[W-1:0]);
        nq = ovf && sat ? lim : sum[W-1:0];
    end
endmodule

// File: rtl/param_accumulator.sv
// param_accumulator: registered add/subtract accumulator with sticky overflow and operation counter
module param_accumulator
    import param_accumulator_pkg::*;
#(
    parameter int IN_W     = 4,
    parameter int ACC_W    = 8,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0,
    parameter int CNT_W    = 8
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             CE,
    input  logic             SCLR,
    input  logic             LOAD,
    input  logic             SUB,
    input  logic [IN_W-1:0]  D,
    output logic [ACC_W-1:0] Q,
    output logic             OVF,
    output logic [CNT_W-1:0] N
);
    logic [ACC_W-1:0] dx;
    logic [ACC_W-1:0] nq;
    logic             ev;

    always_comb begin
        dx = {ACC_W{SIGNED != 0 && D[IN_W-1]}};
        dx[IN_W-1:0] = D;
    end

    param_accumulator_addsub_sat #(.W(ACC_W)) u_addsub (
        .q   (Q),
        .d   (dx),
        .sub (SUB),
        .sgn (SIGNED != 0),
        .sat (SATURATE != 0),
        .nq  (nq),
        .ovf (ev)
    );

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            Q   <= '0;
            OVF <= 1'b0;
            N   <= '0;
        end else if (SCLR) begin
            Q   <= '0;
            OVF <= 1'b0;
            N   <= '0;
        end else if (LOAD) begin
            Q   <= dx;
            OVF <= 1'b0;
            N   <= '0;
        end else if (CE) begin
            Q   <= nq;
            OVF <= OVF | ev;
            N   <= N + 1'b1;
        end
    end
endmodule
